divider_seq: RTL
================

DIVIDER_SEQ -- requirements
Module: divider_seq

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter: WIDTH, default 4, operand/result width in bits.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: rst  input  1  asynchronous active-high reset.
REQ-005 Port: start  input  1  request a division; sampled only in IDLE.
REQ-006 Port: dividend  input  WIDTH  unsigned dividend; captured on accepted start.
REQ-007 Port: divisor  input  WIDTH  unsigned divisor; captured on accepted start.
REQ-008 Port: busy  output  1  high in CALC and DONE states.
REQ-009 Port: done  output  1  one-cycle pulse; quotient/remainder valid.
REQ-010 Port: quotient  output  WIDTH  unsigned quotient.
REQ-011 Port: remainder  output  WIDTH  unsigned remainder.
REQ-012 Port: div_by_zero  output  1  high with done when captured divisor was 0.

Function
REQ-013 The FSM SHALL have states IDLE, CALC, DONE.
REQ-014 IDLE -> CALC on start=1; operands captured that edge, iteration counter cleared.
REQ-015 Algorithm: restoring division, one quotient bit per CALC cycle, MSB first.
REQ-016 Each CALC cycle: partial remainder (WIDTH+1 bits) shifted left, next dividend MSB shifted in, divisor trial-subtracted via sub-module in subtract mode.
REQ-017 Trial result non-negative (no borrow): keep it, quotient bit 1; else restore partial remainder, quotient bit 0.
REQ-018 CALC SHALL last exactly WIDTH cycles, then -> DONE.
REQ-019 DONE lasts one cycle, done=1, then -> IDLE unconditionally.
REQ-020 Latency: done asserted WIDTH+1 cycles after the edge accepting start.
REQ-021 quotient, remainder, div_by_zero SHALL update only on entry to DONE and hold until the next DONE.
REQ-022 start in CALC or DONE SHALL be ignored; no queuing.
REQ-023 Invariant for divisor!=0: dividend = quotient*divisor + remainder, remainder < divisor.
REQ-024 Divisor 0: quotient = all ones, remainder = dividend.

Reset
REQ-025 rst=1 SHALL immediately force IDLE and drive busy, done, quotient, remainder, div_by_zero to 0, regardless of clock.
REQ-026 Reset mid-CALC SHALL abandon the operation; no done pulse follows.
REQ-027 First start accepted on the first rising edge after rst deasserts.

Configuration
REQ-028 Macro DIV_ZERO_DETECT_EN SHALL gate divide-by-zero shortcut logic.
REQ-029 Defined: divisor 0 at start -> IDLE goes directly to DONE next cycle (latency 1), div_by_zero=1, results per REQ-024.
REQ-030 Undefined: divisor 0 runs normal WIDTH-cycle algorithm (yields REQ-024 results naturally); div_by_zero tied 0.

Structure
REQ-031 Shared package div_pkg SHALL hold the state enum typedef (IDLE, CALC, DONE) and the default-width constant.
REQ-032 One sub-module, addsub_stage: combinational WIDTH+1-bit ripple add/subtract with sel input (sel=1 subtract via invert-B and carry-in 1), outputs result and carry-out; the divider instantiates it with sel=1.

Verification
REQ-033 Dividend 13, divisor 4, start -> 5 cycles later done=1, quotient 3, remainder 1, div_by_zero 0.
REQ-034 Dividend 15, divisor 1 -> quotient 15, remainder 0; dividend 3, divisor 7 -> quotient 0, remainder 3.
REQ-035 Dividend 9, divisor 0, macro defined -> done 1 cycle after start, quotient 15, remainder 9, div_by_zero 1; macro undefined -> done after 5 cycles, same quotient/remainder, div_by_zero 0.
REQ-036 start pulsed again during CALC with different operands -> ignored; original result delivered, single done pulse.
REQ-037 rst asserted 2 cycles into CALC -> outputs 0 immediately, no done; new start after release -> correct result with standard latency.
REQ-038 Exhaustive sweep of all 16x15 nonzero-divisor pairs -> REQ-023 invariant holds every case.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

   // Divider control states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   // Default operand/result width
   localparam int unsigned DIV_WIDTH_DEFAULT = 4;

   // Width of a counter that must hold the values 0 .. n-1 (at least one bit)
   function automatic int unsigned div_cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage : div_pkg

// File: rtl/addsub_stage.sv
// Combinational ripple-carry adder/subtractor.
// sel=0: result = a + b; sel=1: result = a - b (computed as a + ~b + 1).
// cout is the final carry; in subtract mode cout=1 means no borrow (a >= b).
module addsub_stage #(
   parameter int unsigned WIDTH = 5
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sel,
   output logic [WIDTH-1:0] result,
   output logic             cout
);

   // Bit-serial carry chain, LSB first; sel doubles as the carry-in
   always_comb begin : ripple
      logic c;
      logic bi;
      c      = sel;
      bi     = 1'b0;
      result = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         bi        = b[i] ^ sel;
         result[i] = a[i] ^ bi ^ c;
         c         = (a[i] & bi) | (c & (a[i] ^ bi));
      end
      cout = c;
   end

endmodule : addsub_stage

// File: rtl/divider_seq.sv
// Sequential restoring divider: one quotient bit per CALC cycle, MSB first.
// Optional macro DIV_ZERO_DETECT_EN: a zero divisor at start skips CALC and
// goes straight to DONE with div_by_zero=1; when undefined the normal
// iteration runs and div_by_zero is tied low.
module divider_seq
   import div_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int unsigned CNT_W = div_cnt_width(WIDTH);
   localparam int unsigned PR_W  = WIDTH + 1;

   state_e             state_q,  state_d;
   logic [CNT_W-1:0]   cnt_q,    cnt_d;
   logic [PR_W-1:0]    prem_q,   prem_d;
   logic [WIDTH-1:0]   dvd_q,    dvd_d;
   logic [WIDTH-1:0]   dvs_q,    dvs_d;
   logic [WIDTH-1:0]   quot_q,   quot_d;
   logic [WIDTH-1:0]   rem_q,    rem_d;
   logic               busy_q,   busy_d;
   logic               done_q,   done_d;
`ifdef DIV_ZERO_DETECT_EN
   logic               dbz_q,    dbz_d;
`endif

   logic [PR_W-1:0]    shifted;
   logic [PR_W-1:0]    trial;
   logic               no_borrow;
   logic [PR_W-1:0]    prem_next;
   logic [WIDTH-1:0]   dvd_next;

   // Shift the next dividend MSB into the partial remainder
   assign shifted = PR_W'({prem_q, dvd_q[WIDTH-1]});

   addsub_stage #(
      .WIDTH (PR_W)
   ) u_addsub (
      .a      (shifted),
      .b      ({1'b0, dvs_q}),
      .sel    (1'b1),
      .result (trial),
      .cout   (no_borrow)
   );

   // Restore on borrow; the quotient bit shifts into the vacated dividend LSB
   always_comb begin
      prem_next = no_borrow ? trial : shifted;
      dvd_next  = WIDTH'({dvd_q, no_borrow});
   end

   // Next-state, datapath and registered-output logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      prem_d  = prem_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
`ifdef DIV_ZERO_DETECT_EN
      dbz_d   = dbz_q;
`endif

      case (state_q)
         IDLE: begin
            if (start) begin
               dvd_d   = dividend;
               dvs_d   = divisor;
               prem_d  = '0;
               cnt_d   = '0;
               state_d = CALC;
`ifdef DIV_ZERO_DETECT_EN
               if (divisor == '0) begin
                  quot_d  = '1;
                  rem_d   = dividend;
                  dbz_d   = 1'b1;
                  state_d = DONE;
               end
`endif
            end
         end
         CALC: begin
            prem_d = prem_next;
            dvd_d  = dvd_next;
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               quot_d  = dvd_next;
               rem_d   = WIDTH'(prem_next);
`ifdef DIV_ZERO_DETECT_EN
               dbz_d   = 1'b0;
`endif
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   // State and datapath registers, asynchronously cleared
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         prem_q  <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
         dbz_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         prem_q  <= prem_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef DIV_ZERO_DETECT_EN
         dbz_q   <= dbz_d;
`endif
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign quotient  = quot_q;
   assign remainder = rem_q;
`ifdef DIV_ZERO_DETECT_EN
   assign div_by_zero = dbz_q;
`else
   assign div_by_zero = 1'b0;
`endif

endmodule : divider_seq
